// File: rtl/bfp_profile_loader.sv
// Serial profile loader for the bfp stage: collects a 4-byte HDR/WGT/HGT/AGE frame,
// validates it and commits it atomically into the female or male held register set.
module bfp_profile_loader #(
    parameter logic [7:0]  AGE_MAX = 8'd120,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] wf,
    output logic [7:0] hf,
    output logic [7:0] af,
    output logic [7:0] wm,
    output logic [7:0] hm,
    output logic [7:0] am,
    output logic       s,
    output logic       upd,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GW     = 3'd1,
        GH     = 3'd2,
        GA     = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] timer_q;
    logic [15:0] timer_d;
    logic        sex_q;
    logic [7:0]  wgt_q;
    logic [7:0]  hgt_q;
    logic [7:0]  age_q;
    logic [7:0]  wf_q, hf_q, af_q, wm_q, hm_q, am_q;
    logic        s_q, upd_q, err_q;
    logic        accept;
    logic        in_frame;
    logic        timeout_hit;

    // A stalled in-frame cycle aborts when it would be the TIMEOUT-th consecutive
    // one; an accepted byte in that same cycle takes priority over the abort.
    always_comb begin
        accept      = in_valid && in_ready;
        in_frame    = (state_q == GW) || (state_q == GH) || (state_q == GA);
        timer_d     = (timer_q == TIMEOUT) ? timer_q : timer_q + 16'd1;
        timeout_hit = (TIMEOUT != 16'd0) && in_frame && !accept
                      && ((timer_q + 16'd1) == TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= 16'd0;
            sex_q   <= 1'b0;
            wgt_q   <= 8'd0;
            hgt_q   <= 8'd0;
            age_q   <= 8'd0;
            wf_q    <= 8'd0;
            hf_q    <= 8'd0;
            af_q    <= 8'd0;
            wm_q    <= 8'd0;
            hm_q    <= 8'd0;
            am_q    <= 8'd0;
            s_q     <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= 16'd0;
                    if (accept) begin
                        if (in_data[7:4] == 4'hA) begin
                            sex_q   <= in_data[0];
                            state_q <= GW;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                GW: begin
                    if (accept) begin
                        wgt_q   <= in_data;
                        timer_q <= 16'd0;
                        state_q <= GH;
                    end else if (timeout_hit) begin
                        timer_q <= 16'd0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                GH: begin
                    if (accept) begin
                        hgt_q   <= in_data;
                        timer_q <= 16'd0;
                        state_q <= GA;
                    end else if (timeout_hit) begin
                        timer_q <= 16'd0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                GA: begin
                    if (accept) begin
                        age_q   <= in_data;
                        timer_q <= 16'd0;
                        if ((wgt_q != 8'd0) && (hgt_q != 8'd0) && (in_data <= AGE_MAX)) begin
                            state_q <= COMMIT;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        timer_q <= 16'd0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                COMMIT: begin
                    // Only the selected set moves, so the bfp stage never sees a mixed profile.
                    if (sex_q) begin
                        wm_q <= wgt_q;
                        hm_q <= hgt_q;
                        am_q <= age_q;
                    end else begin
                        wf_q <= wgt_q;
                        hf_q <= hgt_q;
                        af_q <= age_q;
                    end
                    s_q     <= sex_q;
                    upd_q   <= 1'b1;
                    timer_q <= 16'd0;
                    state_q <= IDLE;
                end
                default: begin
                    timer_q <= 16'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state_q != COMMIT);
    assign busy     = (state_q != IDLE);
    assign wf       = wf_q;
    assign hf       = hf_q;
    assign af       = af_q;
    assign wm       = wm_q;
    assign hm       = hm_q;
    assign am       = am_q;
    assign s        = s_q;
    assign upd      = upd_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bfp_profile_loader.sv
// Scoreboard bench for bfp_profile_loader: expected events are queued as frames are
// driven and compared against the upd/err pulse, its latency and the held outputs.
module tb_bfp_profile_loader;

    localparam logic [7:0]  AGE_MAX = 8'd120;
    localparam logic [15:0] TIMEOUT = 16'd8;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] wf, hf, af, wm, hm, am;
    logic       s, upd, err, busy;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic [1:0]  kind;   // 0 = upd, 1 = err
        int          lat;
        logic [48:0] outs;
    } exp_t;

    exp_t sb[$];

    logic [7:0]  mWf, mHf, mAf, mWm, mHm, mAm;
    logic        mS;
    logic [48:0] outsNow;

    assign outsNow = {wf, hf, af, wm, hm, am, s};

    bfp_profile_loader #(
        .AGE_MAX (AGE_MAX),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wf       (wf),
        .hf       (hf),
        .af       (af),
        .wm       (wm),
        .hm       (hm),
        .am       (am),
        .s        (s),
        .upd      (upd),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [48:0] modelOuts();
        return {mWf, mHf, mAf, mWm, mHm, mAm, mS};
    endfunction

    // Caller is at a negedge; each byte is held until in_ready lets it through.
    task automatic applyStimulus(input logic [7:0] b[8], input int n);
        for (int i = 0; i < n; i++) begin
            int waitCnt = 0;
            in_data  = b[i];
            in_valid = 1'b1;
            while (!in_ready && waitCnt < 20) begin
                @(negedge clk);
                waitCnt++;
            end
            if (!in_ready) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL stall_bound: in_ready=%b after %0d cycles, want 1", in_ready, waitCnt);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pushErr(input int lat);
        exp_t e;
        e.kind = 2'd1;
        e.lat  = lat;
        e.outs = modelOuts();
        sb.push_back(e);
    endtask

    // Header assumed to carry the sync nibble; payload rules decide commit vs reject.
    task automatic pushFrame(input logic [7:0] hdr, input logic [7:0] w,
                             input logic [7:0] h, input logic [7:0] a);
        exp_t e;
        if (w == 8'd0 || h == 8'd0 || a > AGE_MAX) begin
            pushErr(0);
        end else begin
            if (hdr[0]) begin
                mWm = w; mHm = h; mAm = a;
            end else begin
                mWf = w; mHf = h; mAf = a;
            end
            mS     = hdr[0];
            e.kind = 2'd0;
            e.lat  = 1;
            e.outs = modelOuts();
            sb.push_back(e);
        end
    endtask

    // Scans from the current negedge for the next upd/err pulse (bounded).
    task automatic captureEvent(output logic [1:0] kind, output int lat, output logic [48:0] o);
        kind = 2'd2;
        lat  = -1;
        o    = outsNow;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            if (upd || err) begin
                kind = (upd && err) ? 2'd3 : (upd ? 2'd0 : 2'd1);
                lat  = k;
                o    = outsNow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        {mWf, mHf, mAf, mWm, mHm, mAm, mS} = '0;
        #2;
        testsRun++;
        if (in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
        testsRun++;
        if (outsNow !== 49'd0) begin
            failCount++;
            $display("[TB] FAIL reset_outs: got %h want 0", outsNow);
        end
        testsRun++;
        if ({upd, err, busy} !== 3'b000) begin
            failCount++;
            $display("[TB] FAIL reset_flags: got upd/err/busy=%b want 000", {upd, err, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_female();
        logic [1:0] k; int l; logic [48:0] o; exp_t e;
        pushFrame(8'hA0, 8'h50, 8'hAA, 8'h18);
        applyStimulus('{8'hA0, 8'h50, 8'hAA, 8'h18, 0, 0, 0, 0}, 4);
        testsRun++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL female_commit_cycle: got in_ready=%b busy=%b want 0 1", in_ready, busy);
        end
        captureEvent(k, l, o);
        e = sb.pop_front();
        testsRun++;
        if (k !== e.kind || l != e.lat || o !== e.outs) begin
            failCount++;
            $display("[TB] FAIL female_commit: got kind=%0d lat=%0d outs=%h want kind=%0d lat=%0d outs=%h",
                     k, l, o, e.kind, e.lat, e.outs);
        end
        @(negedge clk);
        testsRun++;
        if ({upd, err, in_ready} !== 3'b001) begin
            failCount++;
            $display("[TB] FAIL female_pulse_width: got upd/err/in_ready=%b want 001", {upd, err, in_ready});
        end
    endtask

    task automatic test_male();
        logic [1:0] k; int l; logic [48:0] o; exp_t e;
        pushFrame(8'hA1, 8'h50, 8'hAA, 8'h18);
        applyStimulus('{8'hA1, 8'h50, 8'hAA, 8'h18, 0, 0, 0, 0}, 4);
        testsRun++;
        if (in_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL male_commit_ready: got %b want 0", in_ready);
        end
        captureEvent(k, l, o);
        e = sb.pop_front();
        testsRun++;
        if (k !== e.kind || l != e.lat || o !== e.outs) begin
            failCount++;
            $display("[TB] FAIL male_commit: got kind=%0d lat=%0d outs=%h want kind=%0d lat=%0d outs=%h",
                     k, l, o, e.kind, e.lat, e.outs);
        end
        @(negedge clk);
    endtask

    task automatic test_bad_header();
        logic [1:0] k; int l; logic [48:0] o; exp_t e;
        pushErr(0);
        applyStimulus('{8'h3C, 0, 0, 0, 0, 0, 0, 0}, 1);
        captureEvent(k, l, o);
        e = sb.pop_front();
        testsRun++;
        if (k !== e.kind || l != e.lat || o !== e.outs || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bad_header: got kind=%0d lat=%0d outs=%h busy=%b want kind=%0d lat=%0d outs=%h busy=0",
                     k, l, o, busy, e.kind, e.lat, e.outs);
        end
        @(negedge clk);
        pushFrame(8'hA0, 8'h40, 8'hA0, 8'h20);
        applyStimulus('{8'hA0, 8'h40, 8'hA0, 8'h20, 0, 0, 0, 0}, 4);
        captureEvent(k, l, o);
        e = sb.pop_front();
        testsRun++;
        if (k !== e.kind || l != e.lat || o !== e.outs) begin
            failCount++;
            $display("[TB] FAIL after_bad_header: got kind=%0d lat=%0d outs=%h want kind=%0d lat=%0d outs=%h",
                     k, l, o, e.kind, e.lat, e.outs);
        end
        @(negedge clk);
    endtask

    // Zero weight and age one above the limit reject; age exactly at the limit commits.
    task automatic test_payload();
        logic [7:0] frames[3][4];
        frames[0] = '{8'hA0, 8'h00, 8'hAA, 8'h18};
        frames[1] = '{8'hA0, 8'h50, 8'hAA, 8'h79};
        frames[2] = '{8'hA0, 8'h66, 8'h77, 8'h78};
        for (int f = 0; f < 3; f++) begin
            logic [1:0] k; int l; logic [48:0] o; exp_t e;
            pushFrame(frames[f][0], frames[f][1], frames[f][2], frames[f][3]);
            applyStimulus('{frames[f][0], frames[f][1], frames[f][2], frames[f][3], 0, 0, 0, 0}, 4);
            captureEvent(k, l, o);
            e = sb.pop_front();
            testsRun++;
            if (k !== e.kind || l != e.lat || o !== e.outs) begin
                failCount++;
                $display("[TB] FAIL payload_%0d: got kind=%0d lat=%0d outs=%h want kind=%0d lat=%0d outs=%h",
                         f, k, l, o, e.kind, e.lat, e.outs);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] k; int l; logic [48:0] o; exp_t e;
        pushErr(int'(TIMEOUT));
        applyStimulus('{8'hA0, 8'h50, 0, 0, 0, 0, 0, 0}, 2);
        captureEvent(k, l, o);
        e = sb.pop_front();
        testsRun++;
        if (k !== e.kind || l != e.lat || o !== e.outs || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_abort: got kind=%0d lat=%0d outs=%h busy=%b want kind=%0d lat=%0d outs=%h busy=0",
                     k, l, o, busy, e.kind, e.lat, e.outs);
        end
        @(negedge clk);
        // Stall for TIMEOUT-1 cycles, then hand over HGT in the TIMEOUT-th cycle.
        pushFrame(8'hA0, 8'h31, 8'h32, 8'h33);
        applyStimulus('{8'hA0, 8'h31, 0, 0, 0, 0, 0, 0}, 2);
        repeat (int'(TIMEOUT) - 1) @(negedge clk);
        testsRun++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_early: got busy=%b err=%b want 1 0", busy, err);
        end
        applyStimulus('{8'h32, 8'h33, 0, 0, 0, 0, 0, 0}, 2);
        captureEvent(k, l, o);
        e = sb.pop_front();
        testsRun++;
        if (k !== e.kind || l != e.lat || o !== e.outs) begin
            failCount++;
            $display("[TB] FAIL timeout_last_cycle_handshake: got kind=%0d lat=%0d outs=%h want kind=%0d lat=%0d outs=%h",
                     k, l, o, e.kind, e.lat, e.outs);
        end
        @(negedge clk);
    endtask

    // Second header arrives during COMMIT and must be held off, not dropped.
    task automatic test_back_to_back();
        logic [1:0] k; int l; logic [48:0] o; exp_t e;
        pushFrame(8'hA0, 8'h11, 8'h22, 8'h33);
        pushFrame(8'hA1, 8'h44, 8'h55, 8'h66);
        void'(sb.pop_front());
        applyStimulus('{8'hA0, 8'h11, 8'h22, 8'h33, 8'hA1, 8'h44, 8'h55, 8'h66}, 8);
        captureEvent(k, l, o);
        e = sb.pop_front();
        testsRun++;
        if (k !== e.kind || l != e.lat || o !== e.outs) begin
            failCount++;
            $display("[TB] FAIL back_to_back: got kind=%0d lat=%0d outs=%h want kind=%0d lat=%0d outs=%h",
                     k, l, o, e.kind, e.lat, e.outs);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [1:0] k; int l; logic [48:0] o; exp_t e;
        applyStimulus('{8'hA1, 8'h50, 8'hAA, 0, 0, 0, 0, 0}, 3);
        testsRun++;
        if (busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midframe_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        {mWf, mHf, mAf, mWm, mHm, mAm, mS} = '0;
        testsRun++;
        if (outsNow !== modelOuts() || {upd, err, busy, in_ready} !== 4'b0001) begin
            failCount++;
            $display("[TB] FAIL midframe_reset: got outs=%h upd/err/busy/rdy=%b want outs=0 0001",
                     outsNow, {upd, err, busy, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pushFrame(8'hA1, 8'h50, 8'hAA, 8'h18);
        applyStimulus('{8'hA1, 8'h50, 8'hAA, 8'h18, 0, 0, 0, 0}, 4);
        captureEvent(k, l, o);
        e = sb.pop_front();
        testsRun++;
        if (k !== e.kind || l != e.lat || o !== e.outs) begin
            failCount++;
            $display("[TB] FAIL after_midframe_reset: got kind=%0d lat=%0d outs=%h want kind=%0d lat=%0d outs=%h",
                     k, l, o, e.kind, e.lat, e.outs);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_female();
        test_male();
        test_bad_header();
        test_payload();
        test_timeout();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/bfp_profile_loader.md
Name: bfp_profile_loader

Overview:
- Upstream feeder for the bfp stage: receives a user's profile as a serial byte stream over a valid/ready handshake.
- Validates each frame and holds the female (wf/hf/af) and male (wm/hm/am) register sets stable, together with the sex select s.
- Its outputs connect 1:1 to the bfp inputs of the same names.
- A frame is committed only when complete and valid; otherwise the held registers are untouched.

Parameters:
- AGE_MAX, 8'd120, largest accepted age byte; a larger age rejects the frame.
- TIMEOUT, 16'd1000, cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept; a byte transfers when in_valid && in_ready at a rising edge.
- wf, hf, af  out  8 each  held female weight, height, age.
- wm, hm, am  out  8 each  held male weight, height, age.
- s  out  1  sex of the last committed frame (0 female, 1 male).
- upd  out  1  one-cycle pulse: a frame was committed.
- err  out  1  one-cycle pulse: a frame was rejected or aborted.
- busy  out  1  a frame is in progress (state not IDLE).

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; wf/hf/af/wm/hm/am = 0; s = 0; upd = err = busy = 0; timer = 0.
- Frame format, 4 bytes in order:
  - HDR: bits [7:4] = 4'hA sync nibble, bit0 = sex, bits [3:1] ignored.
  - WGT, HGT, AGE: payload bytes.
- FSM states: IDLE, GW, GH, GA, COMMIT.
- IDLE, header accepted:
  - Sync nibble = 4'hA: latch sex into a shadow register, go to GW.
  - Otherwise: err = 1 next cycle, stay in IDLE.
- GW/GH: an accepted byte is latched into shadow weight/height; advance to GH/GA.
- GA: an accepted byte is latched into shadow age.
  - If shadow weight != 0, shadow height != 0 and age <= AGE_MAX: go to COMMIT.
  - Otherwise: err = 1 next cycle, go to IDLE, outputs unchanged.
- COMMIT (exactly one cycle):
  - in_ready = 0.
  - Shadow values are written to the set selected by shadow sex; s <= shadow sex; the other set is unchanged.
  - upd = 1 in the same cycle the new output values become visible.
  - Next state IDLE.
- Latency: the AGE handshake at edge N gives new outputs and upd = 1 after edge N+1.
- in_ready = (state != COMMIT), combinational from state; it is 1 during and after reset.
- Timeout:
  - Timer clears on every accepted byte and on entry to GW; it counts cycles in GW/GH/GA without a handshake.
  - When TIMEOUT != 0 and the timer reaches TIMEOUT: go to IDLE, err pulses, shadow data is discarded.
  - A handshake in the same cycle the timer hits TIMEOUT wins: the byte is accepted and there is no abort.
- busy = (state != IDLE).
- upd and err are registered and never assert in the same cycle.
- in_valid with in_ready = 0 is held off; the byte is not lost.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded.
- Outputs change only at COMMIT or reset, so the bfp stage always sees a consistent set.
- Widths: all comparisons are unsigned 8-bit; the timer is 16-bit and saturates at TIMEOUT.

Test Plan:
- Reset then stream A0,50,AA,18 with in_valid held → after the AGE edge+1: wf=50h, hf=AAh, af=18h, s=0, upd=1 for one cycle; male set stays 0.
- Stream A1,50,AA,18 following the previous frame → wm/hm/am = 50h/AAh/18h, s=1; female set unchanged; in_ready=0 exactly in the COMMIT cycle.
- Header 3C → err pulse, state stays IDLE; the following A0,40,A0,20 frame commits normally.
- A0,00,AA,18 (zero weight), and separately A0,50,AA,79 with AGE_MAX=120 → err pulse, no upd, all outputs unchanged.
- A0,50 then in_valid low for TIMEOUT=8 cycles → err at the 8th idle cycle, busy falls; the next full frame commits. A handshake on the 8th cycle must not abort.
- rst_n pulsed low after A1,50,AA → all outputs 0 immediately, busy=0, no upd; a fresh frame loads correctly.
